// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
//
// Write-side master for the register file. Merges single-cycle ALU results and
// handshaked load results onto the file's single write port. ALU results always
// win the port; load results wait in a small FIFO. A buffered load is cancelled
// (killed) when a later ALU result targets the same register, so the register
// file never sees an older load overwrite a younger ALU result.
//
// Parameters
//   WIDTH       data width, matches the register file
//   DEPTH       load FIFO entries, power of two, >= 2
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         asynchronous, active-low reset
//   alu_valid   ALU result present this cycle (no backpressure)
//   alu_rd      ALU destination register
//   alu_data    ALU result
//   ld_valid    load result offered
//   ld_ready    FIFO can accept a load
//   ld_rd       load destination register
//   ld_data     load result
//   rd_addr     register-file write address (registered)
//   write_data  register-file write data (registered)
//   regWrite    register-file write enable (registered)
//   ld_empty    FIFO holds no entries
// -----------------------------------------------------------------------------
module writeback_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [4:0]       alu_rd,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [4:0]       ld_rd,
    input  logic [WIDTH-1:0] ld_data,
    output logic [4:0]       rd_addr,
    output logic [WIDTH-1:0] write_data,
    output logic             regWrite,
    output logic             ld_empty
);

    // Pointer width; DEPTH is a power of two so pointers wrap naturally.
    localparam int AW = $clog2(DEPTH);
    // Count must represent 0..DEPTH inclusive.
    localparam int CW = AW + 1;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [DEPTH-1:0] r_kill;
    logic [4:0]       r_fifo_rd   [DEPTH];
    logic [WIDTH-1:0] r_fifo_data [DEPTH];

    // Registered write-port outputs
    logic             r_reg_write;
    logic [4:0]       r_rd_addr;
    logic [WIDTH-1:0] r_write_data;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic             w_alu_live;
    logic             w_fifo_nonempty;
    logic             w_push;
    logic             w_pop;
    logic             w_head_writes;
    logic [AW-1:0]    w_slot_offset [DEPTH];
    logic [DEPTH-1:0] w_kill_hit;

    // Writes to x0 are meaningless, so an ALU result aimed at x0 is no request.
    assign w_alu_live      = alu_valid && (alu_rd != 5'd0);
    assign w_fifo_nonempty = (r_count != '0);

    // Gating with rst keeps the load source stalled for the whole reset window.
    assign ld_ready = rst && (r_count < CW'(DEPTH));
    assign ld_empty = (r_count == '0);

    assign w_push = ld_valid && ld_ready;
    // An accepted ALU result owns the write port, so the FIFO cannot drain.
    assign w_pop  = !w_alu_live && w_fifo_nonempty;

    // A popped head only reaches the port if it survived and is not aimed at x0.
    assign w_head_writes = !r_kill[r_rptr] && (r_fifo_rd[r_rptr] != 5'd0);

    // Mark every occupied entry whose destination matches the live ALU write.
    // An entry is occupied when its distance from the read pointer (modulo
    // DEPTH) is below the current count. The slot receiving a push on the same
    // edge is unoccupied here, so a same-edge load is treated as younger.
    always_comb begin
        // NOTE: every always_comb output gets a default before any conditional
        // logic, so no path leaves it unassigned and no latch is inferred.
        w_kill_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_slot_offset[i] = AW'(i) - r_rptr;
            w_kill_hit[i]    = w_alu_live
                               && ({1'b0, w_slot_offset[i]} < r_count)
                               && (r_fifo_rd[i] == alu_rd);
        end
    end

    // ------------------------------------------------------------------
    // FIFO control state: pointers, count and kill bits
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_kill  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end

            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            for (int i = 0; i < DEPTH; i++) begin
                if (w_kill_hit[i]) begin
                    r_kill[i] <= 1'b1;
                end
            end
            // A freshly pushed entry always starts alive.
            if (w_push) begin
                r_kill[r_wptr] <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO payload storage
    // ------------------------------------------------------------------
    // NOTE: the payload array is deliberately not reset; an entry is only
    // ever read after a push has written it, and the count/kill state that
    // qualifies it is reset above.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wptr]   <= ld_rd;
            r_fifo_data[r_wptr] <= ld_data;
        end
    end

    // ------------------------------------------------------------------
    // Write-port selection: ALU first, then FIFO head, else idle.
    // Address and data hold whenever no write is issued.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg_write  <= 1'b0;
            r_rd_addr    <= '0;
            r_write_data <= '0;
        end else if (w_alu_live) begin
            r_reg_write  <= 1'b1;
            r_rd_addr    <= alu_rd;
            r_write_data <= alu_data;
        end else if (w_fifo_nonempty) begin
            // The head is consumed even when killed; only the write is dropped.
            r_reg_write <= w_head_writes;
            if (w_head_writes) begin
                r_rd_addr    <= r_fifo_rd[r_rptr];
                r_write_data <= r_fifo_data[r_rptr];
            end
        end else begin
            r_reg_write <= 1'b0;
        end
    end

    assign regWrite   = r_reg_write;
    assign rd_addr    = r_rd_addr;
    assign write_data = r_write_data;

endmodule

// File: tb/tb_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_writeback_arbiter
//
// Directed bench for writeback_arbiter. Stimulus tasks push each expected
// register-file write, tagged with the clock edge it must follow, into a
// queue. A monitor on the falling edge compares the write port every cycle:
// a write is required exactly when the queue head is due, otherwise
// regWrite must be low.
// -----------------------------------------------------------------------------
module tb_writeback_arbiter;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             alu_valid;
    logic [4:0]       alu_rd;
    logic [WIDTH-1:0] alu_data;
    logic             ld_valid;
    logic             ld_ready;
    logic [4:0]       ld_rd;
    logic [WIDTH-1:0] ld_data;
    logic [4:0]       rd_addr;
    logic [WIDTH-1:0] write_data;
    logic             regWrite;
    logic             ld_empty;

    writeback_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .rd_addr    (rd_addr),
        .write_data (write_data),
        .regWrite   (regWrite),
        .ld_empty   (ld_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               cyc;
        logic [4:0]       rd;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;
    int   b;

    // Edge counter: the value of cyc after edge N is N.
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic expect_write(input int c, input logic [4:0] rd, input logic [WIDTH-1:0] d);
        exp_t e;
        e.cyc  = c;
        e.rd   = rd;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic av, input logic [4:0] ar, input logic [WIDTH-1:0] ad,
                         input logic lv, input logic [4:0] lr, input logic [WIDTH-1:0] ldd);
        alu_valid = av;
        alu_rd    = ar;
        alu_data  = ad;
        ld_valid  = lv;
        ld_rd     = lr;
        ld_data   = ldd;
    endtask

    // Apply inputs for the next edge, then return just after that edge.
    task automatic step(input logic av, input logic [4:0] ar, input logic [WIDTH-1:0] ad,
                        input logic lv, input logic [4:0] lr, input logic [WIDTH-1:0] ldd);
        drive(av, ar, ad, lv, lr, ldd);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    endtask

    // Write-port monitor, sampled away from the rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                mon_e = exp_q.pop_front();
                check($sformatf("c%0d regWrite", cyc), regWrite, 1'b1);
                check($sformatf("c%0d rd_addr", cyc), rd_addr, mon_e.rd);
                check($sformatf("c%0d write_data", cyc), write_data, mon_e.data);
            end else begin
                check($sformatf("c%0d regWrite_idle", cyc), regWrite, 1'b0);
            end
        end
    end

    initial begin
        rst = 1'b0;
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        #2;
        check("reset regWrite", regWrite, 1'b0);
        check("reset rd_addr", rd_addr, 5'd0);
        check("reset write_data", write_data, '0);
        check("reset ld_ready", ld_ready, 1'b0);
        check("reset ld_empty", ld_empty, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post-reset ld_ready", ld_ready, 1'b1);
        mon_en = 1'b1;

        // ALU only, then an ALU result aimed at x0 (no write, port holds).
        b = cyc;
        expect_write(b + 1, 5'd5, 32'hDEADBEEF);
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, '0);
        step(1'b1, 5'd0, 32'hCAFEF00D, 1'b0, 5'd0, '0);
        check("x0 alu rd_addr hold", rd_addr, 5'd5);
        check("x0 alu write_data hold", write_data, 32'hDEADBEEF);
        idle();

        // Loads fill the FIFO behind ALU writes; a third load is refused.
        b = cyc;
        expect_write(b + 1, 5'd10, 32'h0000A0A0);
        expect_write(b + 2, 5'd11, 32'h0000B1B1);
        expect_write(b + 3, 5'd3,  32'h00003333);
        expect_write(b + 4, 5'd4,  32'h00004444);
        step(1'b1, 5'd10, 32'h0000A0A0, 1'b1, 5'd3, 32'h00003333);
        check("one entry ld_ready", ld_ready, 1'b1);
        check("one entry ld_empty", ld_empty, 1'b0);
        step(1'b1, 5'd11, 32'h0000B1B1, 1'b1, 5'd4, 32'h00004444);
        check("full ld_ready", ld_ready, 1'b0);
        step(1'b0, 5'd0, '0, 1'b1, 5'd9, 32'h00009999);
        check("after pop ld_ready", ld_ready, 1'b1);
        idle();
        check("drained ld_empty", ld_empty, 1'b1);
        idle();

        // Priority: ALU write to another register delays the FIFO head.
        b = cyc;
        expect_write(b + 2, 5'd8, 32'h00000088);
        expect_write(b + 3, 5'd6, 32'h00000066);
        step(1'b0, 5'd0, '0, 1'b1, 5'd6, 32'h00000066);
        step(1'b1, 5'd8, 32'h00000088, 1'b0, 5'd0, '0);
        check("count held over alu", ld_empty, 1'b0);
        idle();
        idle();
        check("priority ld_empty", ld_empty, 1'b1);

        // Kill: buffered x7 load cancelled by a later ALU write to x7.
        b = cyc;
        expect_write(b + 2, 5'd7, 32'h00000022);
        step(1'b0, 5'd0, '0, 1'b1, 5'd7, 32'h00000011);
        step(1'b1, 5'd7, 32'h00000022, 1'b0, 5'd0, '0);
        idle();
        check("killed pop ld_empty", ld_empty, 1'b1);
        idle();

        // Same-edge ALU write and load push to x7: load is younger, both write.
        b = cyc;
        expect_write(b + 1, 5'd7, 32'h00000022);
        expect_write(b + 2, 5'd7, 32'h00000033);
        step(1'b1, 5'd7, 32'h00000022, 1'b1, 5'd7, 32'h00000033);
        idle();
        idle();

        // Kill only the second entry; the head still writes.
        b = cyc;
        expect_write(b + 1, 5'd20, 32'h00002020);
        expect_write(b + 2, 5'd21, 32'h00002121);
        expect_write(b + 3, 5'd8,  32'h00000066);
        expect_write(b + 4, 5'd7,  32'h00000044);
        step(1'b1, 5'd20, 32'h00002020, 1'b1, 5'd7, 32'h00000044);
        step(1'b1, 5'd21, 32'h00002121, 1'b1, 5'd8, 32'h00000055);
        step(1'b1, 5'd8,  32'h00000066, 1'b0, 5'd0, '0);
        idle();
        idle();
        check("second kill ld_empty", ld_empty, 1'b1);

        // Load to x0 occupies a slot but never writes.
        step(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'h00000005);
        check("x0 load ld_empty", ld_empty, 1'b0);
        idle();
        check("x0 load drained", ld_empty, 1'b1);

        // Streaming push+pop with one entry held; pointers wrap repeatedly.
        b = cyc;
        step(1'b0, 5'd0, '0, 1'b1, 5'd1, 32'h00000101);
        for (int k = 2; k <= 9; k++) begin
            expect_write(b + k, 5'(k - 1), 32'h00000100 + 32'(k - 1));
            step(1'b0, 5'd0, '0, 1'b1, 5'(k), 32'h00000100 + 32'(k));
            check($sformatf("stream %0d ld_empty", k), ld_empty, 1'b0);
            check($sformatf("stream %0d ld_ready", k), ld_ready, 1'b1);
        end
        expect_write(b + 10, 5'd9, 32'h00000109);
        idle();
        check("stream drained", ld_empty, 1'b1);

        // Reset with two loads buffered: they must never be written.
        b = cyc;
        expect_write(b + 1, 5'd12, 32'h0000000C);
        expect_write(b + 2, 5'd14, 32'h0000000E);
        step(1'b1, 5'd12, 32'h0000000C, 1'b1, 5'd13, 32'h0000000D);
        step(1'b1, 5'd14, 32'h0000000E, 1'b1, 5'd15, 32'h0000000F);
        check("pre-reset full ld_ready", ld_ready, 1'b0);
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("async reset regWrite", regWrite, 1'b0);
        check("async reset rd_addr", rd_addr, 5'd0);
        check("async reset write_data", write_data, '0);
        check("async reset ld_ready", ld_ready, 1'b0);
        check("async reset ld_empty", ld_empty, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("release ld_ready", ld_ready, 1'b1);
        check("release ld_empty", ld_empty, 1'b1);
        repeat (4) idle();

        check("scoreboard drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
